x_lut7_loader: RTL and testbench



---
 rtl/x_lut7_pkg.sv | 22 ++
 rtl/x_lut7_shadow.sv | 29 ++
 rtl/x_lut7_loader.sv | 132 +++++++++++++
 tb/tb_x_lut7_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/x_lut7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : x_lut7_pkg
// Brief    : Shared widths and FSM state type for the LUT7 table loader.
// Revision : 1.0
// ============================================================================
package x_lut7_pkg;

    localparam int TABLE_W     = 128;
    localparam int BYTE_W      = 8;
    localparam int FRAME_BYTES = 16;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        DRAIN  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/x_lut7_shadow.sv
`default_nettype none
// ============================================================================
// Module   : x_lut7_shadow
// Brief    : 128-bit shadow register written one byte at a time by index.
// Revision : 1.0
// ============================================================================
module x_lut7_shadow
    import x_lut7_pkg::*;
(
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [CNT_W-1:0]   idx_i,
    input  logic [BYTE_W-1:0]  data_i,
    output logic [TABLE_W-1:0] shadow_o
);

    logic [TABLE_W-1:0] shadow_q;

    // Contents are only meaningful once a full frame has been written, so no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            shadow_q[{idx_i, 3'b000} +: BYTE_W] <= data_i;
        end
    end

    assign shadow_o = shadow_q;

endmodule
`default_nettype wire

// File: rtl/x_lut7_loader.sv
`default_nettype none
// ============================================================================
// Module   : x_lut7_loader
// Brief    : Byte-stream loader with atomic commit for a reloadable 7-input LUT.
// Revision : 1.0
// ============================================================================
module x_lut7_loader
    import x_lut7_pkg::*;
#(
    parameter logic [TABLE_W-1:0] INIT = '0,
    parameter string              LOC  = "UNPLACED"
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LD_VALID,
    input  logic [BYTE_W-1:0] LD_DATA,
    input  logic              LD_LAST,
    output logic              LD_READY,
    input  logic [6:0]        ADR,
    output logic              O,
    output logic              CFG_DONE,
    output logic              ERR
);

    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TABLE_W-1:0] active_q;
    logic [TABLE_W-1:0] shadow;
    logic               o_q, done_q, err_q;
    logic               ready, accept, byte_we, err_d, done_d;

    // Placement hint only; both branches are intentionally empty.
    if (LOC == "UNPLACED") begin : g_unplaced
    end else begin : g_placed
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept && !LD_LAST) begin
                    state_d = LOAD;
                    cnt_d   = CNT_W'(1);
                end
            end
            LOAD: begin
                if (accept) begin
                    if (cnt_q == C_LAST_IDX) begin
                        state_d = LD_LAST ? COMMIT : DRAIN;
                        cnt_d   = '0;
                    end else if (LD_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            DRAIN: begin
                cnt_d = '0;
                if (accept && LD_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Ready drops combinationally under reset so no byte is taken while RST is high.
    always_comb begin
        ready   = !RST && (state_q != COMMIT);
        accept  = LD_VALID && ready;
        byte_we = accept && ((state_q == IDLE) || (state_q == LOAD));
        err_d   = accept && LD_LAST &&
                  ((state_q == IDLE) || (state_q == DRAIN) ||
                   ((state_q == LOAD) && (cnt_q != C_LAST_IDX)));
        done_d  = (state_q == COMMIT);
    end

    x_lut7_shadow u_shadow (
        .clk_i    (CLK),
        .we_i     (byte_we),
        .idx_i    (cnt_q),
        .data_i   (LD_DATA),
        .shadow_o (shadow)
    );

    // Lookup reads active_q before the commit lands, so O never mixes tables.
    always_ff @(posedge CLK) begin
        if (RST) begin
            active_q <= INIT;
            o_q      <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            o_q    <= active_q[ADR];
            done_q <= done_d;
            err_q  <= err_d;
            if (done_d) begin
                active_q <= shadow;
            end
        end
    end

    assign LD_READY = ready;
    assign O        = o_q;
    assign CFG_DONE = done_q;
    assign ERR      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_x_lut7_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_x_lut7_loader
// Brief    : Self-checking bench for x_lut7_loader against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_x_lut7_loader;

    localparam logic [127:0] INIT_V = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

    logic       CLK = 1'b0;
    logic       RST, LD_VALID, LD_LAST, LD_READY, O, CFG_DONE, ERR;
    logic [7:0] LD_DATA;
    logic [6:0] ADR;

    always #5 CLK = ~CLK;

    x_lut7_loader #(.INIT(INIT_V), .LOC("UNPLACED")) dut (
        .CLK      (CLK),
        .RST      (RST),
        .LD_VALID (LD_VALID),
        .LD_DATA  (LD_DATA),
        .LD_LAST  (LD_LAST),
        .LD_READY (LD_READY),
        .ADR      (ADR),
        .O        (O),
        .CFG_DONE (CFG_DONE),
        .ERR      (ERR)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Frame-level reference: collect accepted bytes, judge the frame on LD_LAST.
    logic [127:0] m_active = INIT_V;
    logic [127:0] m_pend   = '0;
    logic [7:0]   m_q[$];
    bit           m_commit = 1'b0;
    logic         m_o = 1'b0, m_done = 1'b0, m_err = 1'b0;

    logic       ready_s, o_s, done_s, err_s;
    logic [6:0] cur_adr = 7'd0;

    typedef struct {
        logic [6:0] adr;
        logic       exp;
    } lk_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge(input logic rst, input logic v, input logic [7:0] d,
                              input logic last, input logic [6:0] adr);
        bit acc;
        if (rst) begin
            m_active = INIT_V;
            m_o      = 1'b0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_commit = 1'b0;
            m_q.delete();
        end else begin
            m_o    = m_active[adr];
            m_done = m_commit;
            m_err  = 1'b0;
            acc    = v && !m_commit;
            if (m_commit) begin
                m_active = m_pend;
                m_commit = 1'b0;
            end
            if (acc) begin
                m_q.push_back(d);
                if (last) begin
                    if (m_q.size() == 16) begin
                        for (int k = 0; k < 16; k++) m_pend[8*k +: 8] = m_q[k];
                        m_commit = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_q.delete();
                end
            end
        end
    endtask

    // One clock: drive after negedge, check ready before the edge, outputs after it.
    task automatic step(input logic rst, input logic v, input logic [7:0] d,
                        input logic last, input logic [6:0] adr);
        RST = rst; LD_VALID = v; LD_DATA = d; LD_LAST = last; ADR = adr;
        #1;
        ready_s = LD_READY;
        chk("model_ready", LD_READY, !rst && !m_commit);
        @(posedge CLK);
        model_edge(rst, v, d, last, adr);
        #1;
        o_s = O; done_s = CFG_DONE; err_s = ERR;
        chk("model_O", O, m_o);
        chk("model_CFG_DONE", CFG_DONE, m_done);
        chk("model_ERR", ERR, m_err);
        @(negedge CLK);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'($urandom), 1'($urandom), cur_adr);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input int gap_pct);
        int tries = 0;
        while (tries < 3 && $urandom_range(99) < gap_pct) begin
            idle();
            tries++;
        end
        tries = 0;
        do begin
            step(1'b0, 1'b1, d, last, cur_adr);
            tries++;
        end while (!ready_s && tries < 4);
        if (!ready_s) chk("accept_timeout", ready_s, 1'b1);
    endtask

    task automatic send_frame(input logic [127:0] tbl, input int gap_pct);
        for (int k = 0; k < 16; k++) send_byte(tbl[8*k +: 8], k == 15, gap_pct);
    endtask

    task automatic lookup(input string name, input logic [6:0] adr, input logic exp);
        step(1'b0, 1'b0, 8'($urandom), 1'($urandom), adr);
        chk(name, o_s, exp);
    endtask

    initial begin
        lk_t          lk_rst[5];
        lk_t          lk_a5[6];
        logic [127:0] tbl;

        lk_rst = '{'{7'd0, 1'b1}, '{7'd127, 1'b1}, '{7'd64, 1'b0},
                   '{7'd1, 1'b0}, '{7'd126, 1'b0}};
        lk_a5  = '{'{7'd0, 1'b1}, '{7'd1, 1'b0}, '{7'd7, 1'b1},
                   '{7'd2, 1'b1}, '{7'd6, 1'b0}, '{7'd127, 1'b1}};

        RST = 1'b1; LD_VALID = 1'b0; LD_DATA = '0; LD_LAST = 1'b0; ADR = '0;
        @(negedge CLK);

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'hFF, 1'b0, 7'd0);
            chk("rst_ready", ready_s, 1'b0);
            chk("rst_O", o_s, 1'b0);
            chk("rst_done", done_s, 1'b0);
            chk("rst_err", err_s, 1'b0);
        end
        for (int i = 0; i < 5; i++) lookup("init_lookup", lk_rst[i].adr, lk_rst[i].exp);

        // Full load of A5 bytes, no gaps
        send_frame({16{8'hA5}}, 0);
        chk("a5_last_ready", ready_s, 1'b1);
        idle();
        chk("a5_commit_ready", ready_s, 1'b0);
        chk("a5_cfg_done", done_s, 1'b1);
        chk("a5_no_err", err_s, 1'b0);
        idle();
        chk("a5_done_pulse", done_s, 1'b0);
        for (int i = 0; i < 6; i++) lookup("a5_lookup", lk_a5[i].adr, lk_a5[i].exp);

        // Short frame: LD_LAST on byte 5
        for (int k = 0; k < 6; k++) send_byte(8'h3C, k == 5, 0);
        chk("short_err", err_s, 1'b1);
        idle();
        chk("short_err_pulse", err_s, 1'b0);
        chk("short_no_done", done_s, 1'b0);
        lookup("short_keep127", 7'd127, 1'b1);
        lookup("short_keep1", 7'd1, 1'b0);

        // Long frame of 20 bytes, then a good all-ones frame
        for (int k = 0; k < 20; k++) begin
            send_byte(8'h00, k == 19, 0);
            if (k < 19) chk("long_no_err", err_s, 1'b0);
        end
        chk("long_err", err_s, 1'b1);
        idle();
        chk("long_no_done", done_s, 1'b0);
        lookup("long_keep0", 7'd0, 1'b1);
        lookup("long_keep1", 7'd1, 1'b0);
        send_frame({128{1'b1}}, 0);
        idle();
        chk("ff_cfg_done", done_s, 1'b1);
        for (int a = 0; a < 128; a++) lookup("ff_lookup", 7'(a), 1'b1);

        // Zero frame with ADR held at 3 across the commit
        cur_adr = 7'd3;
        send_frame('0, 0);
        chk("cd_O_last", o_s, 1'b1);
        idle();
        chk("cd_done", done_s, 1'b1);
        chk("cd_O_during_done", o_s, 1'b1);
        idle();
        chk("cd_O_after", o_s, 1'b0);

        // Reset mid-load with gaps, then a fresh frame
        for (int k = 0; k < 9; k++) send_byte(8'($urandom), 1'b0, 30);
        step(1'b1, 1'b1, 8'h5A, 1'b0, cur_adr);
        chk("midrst_ready", ready_s, 1'b0);
        chk("midrst_done", done_s, 1'b0);
        for (int i = 0; i < 5; i++) lookup("midrst_init", lk_rst[i].adr, lk_rst[i].exp);
        tbl = {$urandom, $urandom, $urandom, $urandom};
        send_frame(tbl, 30);
        idle();
        chk("midrst_new_done", done_s, 1'b1);
        for (int a = 0; a < 128; a++) lookup("midrst_table", 7'(a), tbl[a]);

        // Reset landing on the COMMIT cycle loses the commit
        send_frame('0, 0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 7'd0);
        chk("rstcommit_done", done_s, 1'b0);
        idle();
        chk("rstcommit_done2", done_s, 1'b0);
        lookup("rstcommit_init0", 7'd0, 1'b1);
        lookup("rstcommit_init127", 7'd127, 1'b1);

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic r, v, l;
            r = ($urandom_range(249) == 0);
            v = ($urandom_range(99) < 70);
            l = (m_q.size() == 15) ? ($urandom_range(99) < 80) : ($urandom_range(99) < 4);
            step(r, v, 8'($urandom), l, 7'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
